// File: rtl/slice_sequencer.sv
// slice_sequencer: emits one SLICE_W-bit slice per handshake from a packed
// word; define SLICE_SEQ_REVERSE_EN to emit the MSB slice first.
module slice_sequencer #(
    parameter int SLICE_W    = 10,
    parameter int NUM_SLICES = 4,
    parameter int IDX_W      = 2,
    parameter int GAP        = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SLICE_W*NUM_SLICES-1:0] in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [SLICE_W-1:0]            out_data,
    output logic [IDX_W-1:0]              out_idx,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy
);
    localparam int IN_W = SLICE_W * NUM_SLICES;
`ifdef SLICE_SEQ_REVERSE_EN
    localparam logic [IDX_W-1:0] FIRST = IDX_W'(NUM_SLICES - 1);
    localparam logic [IDX_W-1:0] LAST  = '0;
`else
    localparam logic [IDX_W-1:0] FIRST = '0;
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_SLICES - 1);
`endif

    typedef enum logic [1:0] {IDLE, SEND, WAIT} stateT;

    stateT            state;
    logic [IN_W-1:0]  wordReg;
    logic [IN_W-1:0]  selWord;
    logic [IN_W-1:0]  shifted;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] nextIdx;
    logic [IDX_W-1:0] selIdx;
    logic [7:0]       gapCnt;
    logic [SLICE_W-1:0] sliceNext;

    assign in_ready = state == IDLE;

    // Slice to load next: the first slice of in_data when accepting, else the following slice of the held word
    always_comb begin
`ifdef SLICE_SEQ_REVERSE_EN
        nextIdx = idx - IDX_W'(1);
`else
        nextIdx = idx + IDX_W'(1);
`endif
        selIdx    = in_ready ? FIRST : nextIdx;
        selWord   = in_ready ? in_data : wordReg;
        shifted   = selWord >> (IN_W'(selIdx) * IN_W'(SLICE_W));
        sliceNext = shifted[SLICE_W-1:0];
    end

    // Sequencer FSM with registered outputs; outputs hold while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wordReg   <= '0;
            idx       <= '0;
            gapCnt    <= '0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        wordReg   <= in_data;
                        idx       <= FIRST;
                        out_data  <= sliceNext;
                        out_idx   <= FIRST;
                        out_last  <= FIRST == LAST;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (idx == LAST) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else if (GAP == 0) begin
                            idx      <= nextIdx;
                            out_data <= sliceNext;
                            out_idx  <= nextIdx;
                            out_last <= nextIdx == LAST;
                        end else begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            gapCnt    <= 8'(GAP);
                            state     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    gapCnt <= gapCnt - 8'd1;
                    if (gapCnt == 8'd1) begin
                        idx       <= nextIdx;
                        out_data  <= sliceNext;
                        out_idx   <= nextIdx;
                        out_last  <= nextIdx == LAST;
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_slice_sequencer.sv
// tb_slice_sequencer: two instances (GAP=0 and GAP=3) checked against a
// slice-schedule model; honours SLICE_SEQ_REVERSE_EN like the design.
module tb_slice_sequencer;
    localparam int NS = 4;
    localparam logic [39:0] WORD = 40'hAA955FFC01;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inValid = 1'b0;
    logic outReady = 1'b0;
    logic [39:0] inData = '0;
    logic [1:0] inRdy, oLast, oValid, busyV;
    logic [1:0][9:0] oData;
    logic [1:0][1:0] oIdx;

    int vectors = 0;
    int miscompares = 0;

    bit mActive[2];
    int mPos[2];
    int mGap[2];
    logic [39:0] mWord[2];
    logic [9:0] t2Exp[4];
    logic [9:0] t5Exp[4];

    always #5 clk = ~clk;

    slice_sequencer #(.GAP(0)) dut0 (
        .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid), .in_ready(inRdy[0]),
        .out_data(oData[0]), .out_idx(oIdx[0]), .out_last(oLast[0]), .out_valid(oValid[0]),
        .out_ready(outReady), .busy(busyV[0])
    );

    slice_sequencer #(.GAP(3)) dut1 (
        .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid), .in_ready(inRdy[1]),
        .out_data(oData[1]), .out_idx(oIdx[1]), .out_last(oLast[1]), .out_valid(oValid[1]),
        .out_ready(outReady), .busy(busyV[1])
    );

    function automatic int gapOf(int k);
        return k == 0 ? 0 : 3;
    endfunction

    function automatic int idxOf(int p);
`ifdef SLICE_SEQ_REVERSE_EN
        return NS - 1 - p;
`else
        return p;
`endif
    endfunction

    function automatic logic [9:0] sliceOf(logic [39:0] w, int i);
        logic [39:0] s;
        s = w >> (i * 10);
        return s[9:0];
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelStep(int k);
        if (!mActive[k]) begin
            if (inValid) begin
                mActive[k] = 1'b1;
                mWord[k] = inData;
                mPos[k] = 0;
                mGap[k] = 0;
            end
        end else if (mGap[k] > 0) begin
            mGap[k]--;
        end else if (outReady) begin
            if (mPos[k] == NS - 1) mActive[k] = 1'b0;
            else begin
                mPos[k]++;
                mGap[k] = gapOf(k);
            end
        end
    endtask

    task automatic compare(int k);
        bit ev;
        string p;
        p = $sformatf("g%0d_", gapOf(k));
        ev = mActive[k] && mGap[k] == 0;
        check({p, "valid"}, 64'(oValid[k]), 64'(ev));
        check({p, "in_ready"}, 64'(inRdy[k]), 64'(!mActive[k]));
        check({p, "busy"}, 64'(busyV[k]), 64'(mActive[k]));
        check({p, "last"}, 64'(oLast[k]), 64'(ev && mPos[k] == NS - 1));
        if (ev) begin
            check({p, "data"}, 64'(oData[k]), 64'(sliceOf(mWord[k], idxOf(mPos[k]))));
            check({p, "idx"}, 64'(oIdx[k]), 64'(idxOf(mPos[k])));
        end
    endtask

    task automatic cycle(bit iv, logic [39:0] d, bit ordy);
        @(negedge clk);
        inValid = iv;
        inData = d;
        outReady = ordy;
        @(posedge clk);
        for (int k = 0; k < 2; k++) modelStep(k);
        #1;
        for (int k = 0; k < 2; k++) compare(k);
    endtask

    task automatic doReset();
        @(negedge clk);
        inValid = 1'b0;
        outReady = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_valid", 64'(oValid[k]), 64'd0);
            check("rst_busy", 64'(busyV[k]), 64'd0);
            check("rst_last", 64'(oLast[k]), 64'd0);
            check("rst_data", 64'(oData[k]), 64'd0);
            check("rst_idx", 64'(oIdx[k]), 64'd0);
            mActive[k] = 1'b0;
            mPos[k] = 0;
            mGap[k] = 0;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) check("rel_in_ready", 64'(inRdy[k]), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1);
    endtask

    initial begin
        int n;
`ifdef SLICE_SEQ_REVERSE_EN
        t2Exp = '{10'h2AA, 10'h155, 10'h3FF, 10'h001};
        t5Exp = '{10'h000, 10'h000, 10'h000, 10'h001};
`else
        t2Exp = '{10'h001, 10'h3FF, 10'h155, 10'h2AA};
        t5Exp = '{10'h001, 10'h000, 10'h000, 10'h000};
`endif
        #12;
        doReset();

        // basic word, full throughput on the GAP=0 instance
        cycle(1'b1, WORD, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("t2_slice", 64'(oData[0]), 64'(t2Exp[i]));
            check("t2_last", 64'(oLast[0]), 64'(i == 3));
            cycle(1'b0, '0, 1'b1);
        end
        drain();

        // backpressure on the second slice
        cycle(1'b1, WORD, 1'b1);
        cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0, 1'b0);
            check("t3_hold_data", 64'(oData[0]), 64'(t2Exp[1]));
            check("t3_hold_idx", 64'(oIdx[0]), 64'(idxOf(1)));
        end
        drain();

        // gap instance: count invalid cycles while busy
        cycle(1'b1, WORD, 1'b1);
        n = 0;
        for (int i = 0; i < 50 && busyV[1]; i++) begin
            if (!oValid[1]) n++;
            cycle(1'b0, '0, 1'b1);
        end
        check("t4_gap_cycles", 64'(n), 64'd9);
        check("t4_idle", 64'(busyV[1]), 64'd0);
        drain();

        // second word held during SEND is taken only after the last slice
        cycle(1'b1, WORD, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 40'h1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("t5_slice", 64'(oData[0]), 64'(t5Exp[i]));
            cycle(1'b0, '0, 1'b1);
        end
        drain();

        // reset in the middle of a word
        cycle(1'b1, WORD, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        check("t6_pre_idx", 64'(oIdx[0]), 64'(idxOf(2)));
        doReset();
        cycle(1'b1, WORD, 1'b1);
        check("t6_restart_idx", 64'(oIdx[0]), 64'(idxOf(0)));
        drain();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(399) == 0) doReset();
            cycle(1'($urandom_range(1)), {8'($urandom), 32'($urandom)}, $urandom_range(9) < 7);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
